// File: rtl/digit_mux_scheduler.sv
// Multiplexed seven-segment digit scheduler: a blank/dwell sequence drives one-hot digit
// enables, and new values commit only at frame boundaries through a shadow buffer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BLANK | all digits off for BLANK_CYCLES; hex_out already shows the next digit
// ST_DRIVE | digit idx enabled for DWELL_CYCLES
module digit_mux_scheduler #(
    parameter int NUM_DIGITS   = 2,
    parameter int DIGIT_W      = 4,
    parameter int DWELL_CYCLES = 100,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_data,
    output logic                          load_ready,
    output logic [DIGIT_W-1:0]            hex_out,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          blank,
    output logic                          frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                               state, state_nxt;
    logic [CNT_W-1:0]                     cnt, cnt_nxt;
    logic [IDX_W-1:0]                     idx, idx_nxt;
    logic                                 frame_end;
    logic                                 pending;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   active;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   shadow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        frame_end = 1'b0;
        digit_en  = '0;
        blank     = 1'b1;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = ST_DRIVE;
                    cnt_nxt   = '0;
                end
            end
            ST_DRIVE: begin
                blank    = 1'b0;
                digit_en = NUM_DIGITS'(1) << idx;
                if (cnt == DWELL_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    frame_end = (idx == IDX_LAST);
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Commit and accept are mutually exclusive: accept needs pending low, commit needs it high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (load_valid && !pending) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end
        end
    end

    assign load_ready = ~pending;
    assign hex_out    = active[idx];

endmodule

// File: tb/tb_digit_mux_scheduler.sv
// Scoreboard bench for digit_mux_scheduler: cycle-arithmetic schedule model, queue of accepted
// values popped by a monitor at each frame commit, plus a second small-parameter instance.
module tb_digit_mux_scheduler;

    localparam int ND = 2, DW = 4, DWELL = 100, BLK = 4;
    localparam int FRAME = ND * (DWELL + BLK);
    localparam int ND5 = 4, DWELL5 = 3, BLK5 = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_ready, blank, frame_done;
    logic [3:0]  hex_out;
    logic [1:0]  digit_en;

    logic        lv5 = 1'b0;
    logic [15:0] ld5 = '0;
    logic        ready5, blank5, fd5;
    logic [3:0]  hex5;
    logic [3:0]  en5;

    digit_mux_scheduler #(.NUM_DIGITS(ND), .DIGIT_W(DW), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLK)) u_dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .hex_out(hex_out), .digit_en(digit_en), .blank(blank),
        .frame_done(frame_done)
    );

    digit_mux_scheduler #(.NUM_DIGITS(ND5), .DIGIT_W(DW), .DWELL_CYCLES(DWELL5), .BLANK_CYCLES(BLK5)) u_dut5 (
        .clk(clk), .reset(reset), .load_valid(lv5), .load_data(ld5),
        .load_ready(ready5), .hex_out(hex5), .digit_en(en5), .blank(blank5),
        .frame_done(fd5)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } item_t;

    item_t      q[$];
    int         cyc = 0;
    bit         run = 0;
    logic [7:0] m_active = '0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int exp_en(input int n, input int nd, input int b, input int d);
        int p;
        p = n % (nd * (b + d));
        return ((p % (b + d)) < b) ? 0 : (1 << (p / (b + d)));
    endfunction

    function automatic int exp_idx(input int n, input int nd, input int b, input int d);
        return (n % (nd * (b + d))) / (b + d);
    endfunction

    function automatic bit exp_fd(input int n, input int nd, input int b, input int d);
        return (n > 0) && ((n % (nd * (b + d))) == 0);
    endfunction

    // Reference: anything presented while nothing is buffered is accepted on this edge.
    always @(posedge clk) begin
        if (run && reset === 1'b1) begin
            if (load_valid === 1'b1 && q.size() == 0)
                q.push_back('{load_data, cyc + 1});
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (run && reset === 1'b1) begin
            int         di;
            logic [3:0] eh;
            item_t      it;
            if (frame_done === 1'b1 && q.size() > 0 && q[0].cyc < cyc) begin
                it = q.pop_front();
                m_active = it.data;
            end
            di = exp_idx(cyc, ND, BLK, DWELL);
            eh = m_active[di*4 +: 4];
            check("digit_en", digit_en, exp_en(cyc, ND, BLK, DWELL));
            check("blank", blank, exp_en(cyc, ND, BLK, DWELL) == 0);
            check("frame_done", frame_done, exp_fd(cyc, ND, BLK, DWELL));
            check("load_ready", load_ready, q.size() == 0);
            check("hex_out", hex_out, eh);
            check("inv_onehot", $countones(digit_en) <= 1, 1);
            check("inv_blank_off", blank && (digit_en != 0), 0);
            check("t5_digit_en", en5, exp_en(cyc, ND5, BLK5, DWELL5));
            check("t5_blank", blank5, exp_en(cyc, ND5, BLK5, DWELL5) == 0);
            check("t5_frame_done", fd5, exp_fd(cyc, ND5, BLK5, DWELL5));
            check("t5_hex_out", hex5, 0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit_en"}, digit_en, 0);
        check({tag, "_blank"}, blank, 1);
        check({tag, "_hex_out"}, hex_out, 0);
        check({tag, "_load_ready"}, load_ready, 1);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_t5_digit_en"}, en5, 0);
        check({tag, "_t5_ready"}, ready5, 1);
    endtask

    task automatic do_release();
        @(negedge clk);
        cyc = 0;
        q.delete();
        m_active = '0;
        run = 1;
        #2 reset = 1'b1;
        #1 check_reset_outputs("cycle0");
    endtask

    task automatic async_reset();
        #3;
        reset = 1'b0;
        run = 0;
        load_valid = 1'b0;
        #1 check_reset_outputs("async");
        #20;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int budget);
        bit done;
        done = 0;
        load_valid = 1'b1;
        load_data = d;
        for (int i = 0; i < budget && !done; i++) begin
            if (load_ready === 1'b1) done = 1;
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_data = 8'($urandom);
        check("send_accepted", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_end;
        #12;
        check_reset_outputs("reset");
        do_release();

        wait_cyc(10);
        send(8'h5A, 50);
        wait_cyc(20);
        send(8'h3C, 3 * FRAME);
        wait_cyc(2 * FRAME + 14);

        async_reset();
        do_release();
        wait_cyc(30);
        send(8'h77, 50);
        wait_cyc(50);
        async_reset();
        do_release();
        wait_cyc(FRAME + 10);

        t_end = cyc + 10 * FRAME;
        while (cyc < t_end) begin
            repeat ($urandom_range(0, 150)) begin
                load_data = 8'($urandom);
                @(negedge clk);
            end
            send(8'($urandom), 3 * FRAME);
        end
        wait_cyc(cyc + 2);
        run = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
